// File: rtl/tt_pinbus_pkg.sv
// Shared types and constants for the pin-bus responder.
// PINBUS_PARITY_EN selects the odd-parity checked build (changes UIO_OE).
package tt_pinbus_pkg;

  localparam int unsigned NREGS  = 8;
  localparam int unsigned ADDR_W = $clog2(NREGS);

  typedef enum logic [1:0] {
    OpNop      = 2'b00,
    OpWrite    = 2'b01,
    OpRead     = 2'b10,
    OpReadNext = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StGetData,
    StResp
  } state_e;

  // uio_in bit positions
  localparam int unsigned UIO_REQ    = 0;
  localparam int unsigned UIO_ABORT  = 1;
  localparam int unsigned UIO_PARITY = 3;
  // uio_out bit positions
  localparam int unsigned UIO_ACK    = 1;
  localparam int unsigned UIO_BUSY   = 2;
  localparam int unsigned UIO_PERR   = 3;

`ifdef PINBUS_PARITY_EN
  localparam logic [7:0] UIO_OE = 8'b0000_1110;
`else
  localparam logic [7:0] UIO_OE = 8'b0000_0110;
`endif

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/tt_pinbus_if.sv
// Pin-level bus between a host (master) and the responder (slave).
interface tt_pinbus_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_pinbus_regfile.sv
// 8x8 register file: one synchronous write port, one combinational read port.
module tt_pinbus_regfile
  import tt_pinbus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata = regs_q[raddr];

endmodule

// File: rtl/tt_pinbus_responder.sv
// Byte-serial command responder on a TinyTapeout-style pin bus.
// Define PINBUS_PARITY_EN to check odd parity on every captured byte.
module tt_pinbus_responder
  import tt_pinbus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  tt_pinbus_if.slave bus
);

  state_e            state_q;
  logic              req_q, ack_q, busy_q, perr_q;
  logic [ADDR_W-1:0] ptr_q, waddr_q;
  logic [7:0]        dout_q;

  op_e               op;
  logic [ADDR_W-1:0] cmd_addr, raddr;
  logic [7:0]        rdata;
  logic              req_edge, abort, byte_ok, wr_en;

  assign op       = op_e'(bus.ui_in[7:6]);
  assign cmd_addr = bus.ui_in[ADDR_W-1:0];
  assign req_edge = bus.ena & bus.uio_in[UIO_REQ] & ~req_q;
  assign abort    = bus.uio_in[UIO_ABORT];

`ifdef PINBUS_PARITY_EN
  assign byte_ok = odd_parity_ok(bus.ui_in, bus.uio_in[UIO_PARITY]);
  logic unused_in;
  assign unused_in = ^{bus.uio_in[7:4], bus.uio_in[2], bus.ui_in[5:3]};
`else
  assign byte_ok = 1'b1;
  logic unused_in;
  assign unused_in = ^{bus.uio_in[7:2], bus.ui_in[5:3]};
`endif

  // Single read port: READ_NEXT reads through the pointer, READ through the command address.
  assign raddr = (op == OpReadNext) ? ptr_q : cmd_addr;
  assign wr_en = (state_q == StGetData) && !abort && req_edge && byte_ok;

  tt_pinbus_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (waddr_q),
    .wdata (bus.ui_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      ptr_q   <= '0;
      waddr_q <= '0;
      dout_q  <= '0;
    end else if (bus.ena) begin
      req_q <= bus.uio_in[UIO_REQ];
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_edge) begin
            if (!byte_ok) begin
              perr_q <= 1'b1;
            end else begin
              unique case (op)
                OpNop: state_q <= StResp;
                OpWrite: begin
                  waddr_q <= cmd_addr;
                  busy_q  <= 1'b1;
                  state_q <= StGetData;
                end
                OpRead: begin
                  dout_q  <= rdata;
                  ptr_q   <= cmd_addr + 1'b1;
                  state_q <= StResp;
                end
                OpReadNext: begin
                  dout_q  <= rdata;
                  ptr_q   <= ptr_q + 1'b1;
                  state_q <= StResp;
                end
                default: state_q <= StIdle;
              endcase
            end
          end
        end
        StGetData: begin
          // Abort wins over a request edge in the same cycle.
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (req_edge) begin
            busy_q <= 1'b0;
            if (!byte_ok) begin
              perr_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              ptr_q   <= waddr_q + 1'b1;
              state_q <= StResp;
            end
          end
        end
        StResp: begin
          ack_q   <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.uo_out = dout_q;
  assign bus.uio_oe = UIO_OE;

  always_comb begin
    bus.uio_out           = '0;
    bus.uio_out[UIO_ACK]  = ack_q;
    bus.uio_out[UIO_BUSY] = busy_q;
    bus.uio_out[UIO_PERR] = perr_q;
  end

endmodule

// File: doc/tt_pinbus_responder.md
TT_PINBUS_RESPONDER -- requirements
Module: tt_pinbus_responder

Interface
REQ-001 SHALL have port clk, input, 1: single design clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port ena, input, 1: design selected; when low, requests are ignored and all state holds.
REQ-004 SHALL have port ui_in, input, 8: command or data byte, sampled on each request edge.
REQ-005 SHALL have port uio_in, input, 8: [0] req strobe (level), [1] abort, [3] parity (PINBUS_PARITY_EN only), others ignored.
REQ-006 SHALL have port uo_out, output, 8: read data, registered.
REQ-007 SHALL have port uio_out, output, 8: [1] ack pulse, [2] busy, [3] parity error (PINBUS_PARITY_EN only, else 0), others 0.
REQ-008 SHALL have port uio_oe, output, 8: constant 8'b0000_1110 with macro, 8'b0000_0110 without.

Function
REQ-009 SHALL register uio_in[0] into req_q each cycle; a request edge is uio_in[0]=1 with req_q=0, sampled at clock edge N while ena=1.
REQ-010 SHALL decode a command byte as {op[1:0], rsvd[2:0], addr[2:0]}: op 00 NOP, 01 WRITE, 10 READ, 11 READ_NEXT.
REQ-011 SHALL use FSM states IDLE, GET_DATA, RESP.
REQ-012 IDLE + request edge: NOP -> RESP; WRITE -> latch addr, busy=1, go to GET_DATA; READ -> uo_out<=reg[addr], ptr<=addr+1, go to RESP; READ_NEXT -> uo_out<=reg[ptr], ptr<=ptr+1, go to RESP.
REQ-013 GET_DATA + request edge: write ui_in into reg[addr], ptr<=addr+1, busy<=0, go to RESP.
REQ-014 GET_DATA with abort=1 SHALL return to IDLE, busy<=0, without a write or an ack; abort takes priority over a simultaneous request edge.
REQ-015 RESP SHALL drive ack=1 for exactly one cycle, i.e. high from edge N+1 to edge N+2, then go to IDLE.
REQ-016 A request edge arriving while in RESP SHALL be dropped, with no ack and no state change.
REQ-017 ptr SHALL be 3 bits and wrap modulo 8 (7 -> 0).
REQ-018 uo_out SHALL hold its last read value until the next READ or READ_NEXT; writes SHALL NOT change uo_out.
REQ-019 With ena=0 the FSM, registers, req_q and outputs SHALL hold; any pending ack completes only once ena returns high.

Reset
REQ-020 On rst_n=0, SHALL asynchronously clear to: FSM=IDLE, all 8 registers=0, ptr=0, req_q=0, uo_out=0, ack=0, busy=0, perr=0.
REQ-021 Reset mid-transaction SHALL discard the transaction; the first request edge after release is treated as a command.

Configuration
REQ-022 With PINBUS_PARITY_EN defined, each captured byte SHALL be checked: ^{ui_in, uio_in[3]} must equal 1 (odd parity).
REQ-023 With PINBUS_PARITY_EN defined, a failing byte SHALL set perr (uio_out[3], sticky until the next reset), drop the transaction (no write, no read update, no ack), and return the FSM to IDLE.
REQ-024 Without PINBUS_PARITY_EN, uio_in[3] SHALL be ignored and uio_out[3]=0.

Structure
REQ-025 Package tt_pinbus_pkg SHALL hold the op enum, the FSM state enum, NREGS=8, and the UIO bit-index and UIO_OE constants.
REQ-026 Storage SHALL be sub-module tt_pinbus_regfile: 8x8 registers, one synchronous write port, one combinational read port, async reset to 0.

Verification
REQ-027 WRITE: cmd 8'h45 then data 8'hA5 -> busy high between the two bytes; ack once after the data byte; later READ (8'h85) returns uo_out=8'hA5 with ack.
REQ-028 READ_NEXT wrap: write reg7=8'h11 and reg0=8'h22; READ 8'h87 -> 11; READ_NEXT 8'hC0 -> 22 (ptr wrapped to 0), then ptr=1.
REQ-029 Abort: cmd 8'h43, assert abort, then data 8'hFF -> no ack for the data byte; READ 8'h83 returns 8'h00.
REQ-030 Reset mid-op: cmd 8'h41, pulse rst_n low, then byte 8'h81 -> treated as READ of reg1, returns 8'h00 with ack.
REQ-031 ena=0: request edges with cmd 8'h42 / data 8'h77 -> no ack and no state change; with ena=1 again, READ 8'h82 returns 8'h00.
REQ-032 PINBUS_PARITY_EN: byte with wrong parity -> no ack and uio_out[3]=1 until reset; the next valid command is processed normally.
